// File: rtl/fetch_queue_icache_if.sv
// fetch_queue_icache_if: PC-controller, decoder and dispatcher signals of the fetch queue
interface fetch_queue_icache_if #(
    parameter int ADDR_W    = 32,
    parameter int INST_W    = 32,
    parameter int DEPTH_LOG = 3
);
    logic                 in_rdy;
    logic                 in_stall;
    logic                 in_flush_enable;
    logic                 in_fetcher_enable;
    logic [ADDR_W-1:0]    in_pc;
    logic                 in_predict;
    logic                 out_pc_fetch_full;
    logic [DEPTH_LOG:0]   out_free_slots;
    logic                 out_pc_last_enable;
    logic [INST_W-1:0]    out_pc_last_inst;
    logic                 out_decoder_decode_enable;
    logic [INST_W-1:0]    out_decoder_pc_inst;
    logic [ADDR_W-1:0]    out_decoder_pc_addr;
    logic                 out_decoder_pc_pre;
    logic                 out_dispatch_pc_requesting;
    logic [ADDR_W-1:0]    out_dispatch_pc_addr;
    logic [INST_W-1:0]    in_dispatch_pc_inst;
    logic                 in_pc_req_enable;
    logic                 in_pc_data_enable;

    modport slave (
        input  in_rdy, in_stall, in_flush_enable, in_fetcher_enable, in_pc, in_predict,
               in_dispatch_pc_inst, in_pc_req_enable, in_pc_data_enable,
        output out_pc_fetch_full, out_free_slots, out_pc_last_enable, out_pc_last_inst,
               out_decoder_decode_enable, out_decoder_pc_inst, out_decoder_pc_addr,
               out_decoder_pc_pre, out_dispatch_pc_requesting, out_dispatch_pc_addr
    );

    modport master (
        output in_rdy, in_stall, in_flush_enable, in_fetcher_enable, in_pc, in_predict,
               in_dispatch_pc_inst, in_pc_req_enable, in_pc_data_enable,
        input  out_pc_fetch_full, out_free_slots, out_pc_last_enable, out_pc_last_inst,
               out_decoder_decode_enable, out_decoder_pc_inst, out_decoder_pc_addr,
               out_decoder_pc_pre, out_dispatch_pc_requesting, out_dispatch_pc_addr
    );
endinterface

// File: rtl/fetch_queue_icache.sv
// fetch_queue_icache: in-order PC queue resolving instructions via direct-mapped icache or memory.
// Cache storage present only when FETCH_QUEUE_ICACHE_EN is defined; otherwise every fill misses.
module fetch_queue_icache #(
    parameter int ADDR_W    = 32,
    parameter int INST_W    = 32,
    parameter int DEPTH_LOG = 3,
    parameter int IDX_BITS  = 8
) (
    input logic in_clk,
    input logic in_rst,
    fetch_queue_icache_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [1:0] EMPTY = 2'd0, PEND = 2'd1, WAIT = 2'd2, READY = 2'd3;

    logic [ADDR_W-1:0]    e_pc   [DEPTH];
    logic                 e_pre  [DEPTH];
    logic [INST_W-1:0]    e_inst [DEPTH];
    logic [1:0]           e_st   [DEPTH];
    logic [DEPTH_LOG-1:0] head, tail, fill;
    logic [DEPTH_LOG:0]   count;
    logic                 outstanding, drop;
    logic                 hit, push, issue, resp, fill_ok;
    logic [INST_W-1:0]    hit_inst;

    assign bus.out_pc_fetch_full = count == (DEPTH_LOG+1)'(DEPTH);
    assign bus.out_free_slots    = (DEPTH_LOG+1)'(DEPTH) - count;
    assign push    = bus.in_fetcher_enable && !bus.out_pc_fetch_full;
    assign issue   = !bus.in_stall && e_st[head] == READY;
    // a response with nothing outstanding (e.g. after reset) is stale and ignored entirely
    assign resp    = bus.in_rdy && bus.in_pc_data_enable && outstanding;
    assign fill_ok = !(resp && !drop);

`ifdef FETCH_QUEUE_ICACHE_EN
    localparam int LINES = 1 << IDX_BITS;
    logic [LINES-1:0]             c_valid;
    logic [ADDR_W-IDX_BITS-3:0]   c_tag  [LINES];
    logic [INST_W-1:0]            c_data [LINES];
    logic [IDX_BITS-1:0]          f_idx, r_idx;
    assign f_idx    = e_pc[fill][IDX_BITS+1:2];
    assign r_idx    = bus.out_dispatch_pc_addr[IDX_BITS+1:2];
    assign hit      = c_valid[f_idx] && c_tag[f_idx] == e_pc[fill][ADDR_W-1:IDX_BITS+2];
    assign hit_inst = c_data[f_idx];
    always_ff @(posedge in_clk or posedge in_rst)
        if (in_rst) c_valid <= '0;
        else if (resp) c_valid[r_idx] <= 1'b1;
    always_ff @(posedge in_clk)
        if (resp) begin
            c_tag[r_idx]  <= bus.out_dispatch_pc_addr[ADDR_W-1:IDX_BITS+2];
            c_data[r_idx] <= bus.in_dispatch_pc_inst;
        end
`else
    assign hit      = 1'b0;
    assign hit_inst = '0;
`endif

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                e_pc[i]   <= '0;
                e_pre[i]  <= 1'b0;
                e_inst[i] <= '0;
                e_st[i]   <= EMPTY;
            end
            head <= '0;
            tail <= '0;
            fill <= '0;
            count <= '0;
            outstanding <= 1'b0;
            drop <= 1'b0;
            bus.out_pc_last_enable <= 1'b0;
            bus.out_pc_last_inst <= '0;
            bus.out_decoder_decode_enable <= 1'b0;
            bus.out_decoder_pc_inst <= '0;
            bus.out_decoder_pc_addr <= '0;
            bus.out_decoder_pc_pre <= 1'b0;
            bus.out_dispatch_pc_requesting <= 1'b0;
            bus.out_dispatch_pc_addr <= '0;
        end else if (bus.in_rdy) begin
            bus.out_pc_last_enable <= 1'b0;
            bus.out_decoder_decode_enable <= 1'b0;
            bus.out_dispatch_pc_requesting <= 1'b0;
            if (bus.in_flush_enable) begin
                for (int i = 0; i < DEPTH; i++) e_st[i] <= EMPTY;
                head <= '0;
                tail <= '0;
                fill <= '0;
                count <= '0;
                // a request still in flight must be discarded when it returns
                outstanding <= outstanding && !resp;
                drop <= outstanding && !resp;
            end else begin
                if (push) begin
                    e_pc[tail]  <= bus.in_pc;
                    e_pre[tail] <= bus.in_predict;
                    e_st[tail]  <= PEND;
                    tail <= tail + 1'b1;
                end
                if (issue) begin
                    bus.out_decoder_decode_enable <= 1'b1;
                    bus.out_decoder_pc_inst <= e_inst[head];
                    bus.out_decoder_pc_addr <= e_pc[head];
                    bus.out_decoder_pc_pre <= e_pre[head];
                    e_st[head] <= EMPTY;
                    head <= head + 1'b1;
                end
                count <= count + (DEPTH_LOG+1)'(push) - (DEPTH_LOG+1)'(issue);
                if (resp) begin
                    outstanding <= 1'b0;
                    drop <= 1'b0;
                    if (!drop) begin
                        e_inst[fill] <= bus.in_dispatch_pc_inst;
                        e_st[fill] <= READY;
                        fill <= fill + 1'b1;
                        bus.out_pc_last_enable <= 1'b1;
                        bus.out_pc_last_inst <= bus.in_dispatch_pc_inst;
                    end
                end
                if (fill_ok && e_st[fill] == PEND) begin
                    if (hit) begin
                        e_inst[fill] <= hit_inst;
                        e_st[fill] <= READY;
                        fill <= fill + 1'b1;
                        bus.out_pc_last_enable <= 1'b1;
                        bus.out_pc_last_inst <= hit_inst;
                    end else if (bus.in_pc_req_enable && !outstanding) begin
                        bus.out_dispatch_pc_requesting <= 1'b1;
                        bus.out_dispatch_pc_addr <= e_pc[fill];
                        e_st[fill] <= WAIT;
                        outstanding <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue_icache.sv
// tb_fetch_queue_icache: directed checks of the fetch queue; expectations follow FETCH_QUEUE_ICACHE_EN.
module tb_fetch_queue_icache;
`ifdef FETCH_QUEUE_ICACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif
    logic in_clk = 1'b0;
    logic in_rst = 1'b1;
    int total = 0;
    int bad = 0;

    fetch_queue_icache_if bus ();
    fetch_queue_icache dut (.in_clk(in_clk), .in_rst(in_rst), .bus(bus));

    always #5 in_clk = ~in_clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge in_clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic pre);
        bus.in_fetcher_enable = 1'b1;
        bus.in_pc = pc;
        bus.in_predict = pre;
        step;
        bus.in_fetcher_enable = 1'b0;
    endtask

    task automatic respond(input logic [31:0] inst);
        bus.in_pc_data_enable = 1'b1;
        bus.in_dispatch_pc_inst = inst;
        step;
        bus.in_pc_data_enable = 1'b0;
    endtask

    task automatic check_dec(input string tag, input logic [31:0] pc, input logic [31:0] inst, input logic pre);
        check({tag, "_en"}, bus.out_decoder_decode_enable, 1);
        check({tag, "_pc"}, bus.out_decoder_pc_addr, pc);
        check({tag, "_inst"}, bus.out_decoder_pc_inst, inst);
        check({tag, "_pre"}, bus.out_decoder_pc_pre, pre);
    endtask

    initial begin
        bus.in_rdy = 1'b1;
        bus.in_stall = 1'b0;
        bus.in_flush_enable = 1'b0;
        bus.in_fetcher_enable = 1'b0;
        bus.in_pc = '0;
        bus.in_predict = 1'b0;
        bus.in_dispatch_pc_inst = '0;
        bus.in_pc_req_enable = 1'b1;
        bus.in_pc_data_enable = 1'b0;
        step;
        step;
        check("rst_dec", bus.out_decoder_decode_enable, 0);
        check("rst_req", bus.out_dispatch_pc_requesting, 0);
        check("rst_last", bus.out_pc_last_enable, 0);
        check("rst_full", bus.out_pc_fetch_full, 0);
        check("rst_free", bus.out_free_slots, 8);
        check("rst_addr", bus.out_dispatch_pc_addr, 0);
        in_rst = 1'b0;
        step;

        // cold miss
        push(32'h100, 1'b1);
        check("t1_req0", bus.out_dispatch_pc_requesting, 0);
        step;
        check("t1_req", bus.out_dispatch_pc_requesting, 1);
        check("t1_addr", bus.out_dispatch_pc_addr, 32'h100);
        respond(32'h13);
        check("t1_last", bus.out_pc_last_enable, 1);
        check("t1_lasti", bus.out_pc_last_inst, 32'h13);
        check("t1_dec0", bus.out_decoder_decode_enable, 0);
        step;
        check_dec("t1_dec", 32'h100, 32'h13, 1'b1);
        step;
        check("t1_dec_off", bus.out_decoder_decode_enable, 0);

        // re-fetch: hit when cached, otherwise another miss
        push(32'h100, 1'b0);
        step;
        check("t2_req", bus.out_dispatch_pc_requesting, !CACHE);
        check("t2_last", bus.out_pc_last_enable, CACHE);
        if (!CACHE) respond(32'h13);
        step;
        check_dec("t2_dec", 32'h100, 32'h13, 1'b0);
        step;

        // fill the queue under stall
        bus.in_stall = 1'b1;
        bus.in_pc_req_enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push(32'h400 + 4 * i, i[0]);
            if (i == 2) check("t3_free3", bus.out_free_slots, 5);
        end
        check("t3_full", bus.out_pc_fetch_full, 1);
        check("t3_free", bus.out_free_slots, 0);
        push(32'h800, 1'b1);
        check("t3_full9", bus.out_pc_fetch_full, 1);
        bus.in_pc_req_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4 && !bus.out_dispatch_pc_requesting; k++) step;
            check("t3_req", bus.out_dispatch_pc_requesting, 1);
            check("t3_addr", bus.out_dispatch_pc_addr, 32'h400 + 4 * i);
            respond(32'hA000 + i);
        end
        check("t3_held", bus.out_decoder_decode_enable, 0);
        bus.in_stall = 1'b0;
        step;
        for (int i = 0; i < 8; i++) begin
            check_dec("t3_dec", 32'h400 + 4 * i, 32'hA000 + i, i[0]);
            step;
        end
        check("t3_dec_off", bus.out_decoder_decode_enable, 0);
        check("t3_free_end", bus.out_free_slots, 8);

        // flush with a request in flight
        push(32'h200, 1'b0);
        step;
        check("t4_req", bus.out_dispatch_pc_requesting, 1);
        check("t4_addr", bus.out_dispatch_pc_addr, 32'h200);
        bus.in_flush_enable = 1'b1;
        step;
        bus.in_flush_enable = 1'b0;
        check("t4_free", bus.out_free_slots, 8);
        push(32'h300, 1'b1);
        check("t4_noreq", bus.out_dispatch_pc_requesting, 0);
        respond(32'h22);
        check("t4_drop", bus.out_pc_last_enable, 0);
        check("t4_noreq2", bus.out_dispatch_pc_requesting, 0);
        step;
        check("t4_req3", bus.out_dispatch_pc_requesting, 1);
        check("t4_addr3", bus.out_dispatch_pc_addr, 32'h300);
        respond(32'h33);
        step;
        check_dec("t4_dec", 32'h300, 32'h33, 1'b1);
        step;
        check("t4_dec_off", bus.out_decoder_decode_enable, 0);
        push(32'h200, 1'b0);
        step;
        check("t4_hit", bus.out_dispatch_pc_requesting, !CACHE);
        if (!CACHE) respond(32'h22);
        step;
        check_dec("t4_dec2", 32'h200, 32'h22, 1'b0);
        step;

        // index conflict evicts
        push(32'h104, 1'b0);
        step;
        check("t5_req1", bus.out_dispatch_pc_requesting, 1);
        respond(32'h11);
        step;
        check_dec("t5_dec1", 32'h104, 32'h11, 1'b0);
        push(32'h504, 1'b1);
        step;
        check("t5_req2", bus.out_dispatch_pc_requesting, 1);
        check("t5_addr2", bus.out_dispatch_pc_addr, 32'h504);
        respond(32'h55);
        step;
        check_dec("t5_dec2", 32'h504, 32'h55, 1'b1);
        push(32'h104, 1'b0);
        step;
        check("t5_req3", bus.out_dispatch_pc_requesting, 1);
        check("t5_addr3", bus.out_dispatch_pc_addr, 32'h104);
        respond(32'h11);
        step;
        check_dec("t5_dec3", 32'h104, 32'h11, 1'b0);
        step;

        // global enable low freezes the queue
        bus.in_rdy = 1'b0;
        bus.in_fetcher_enable = 1'b1;
        bus.in_pc = 32'h900;
        step;
        bus.in_fetcher_enable = 1'b0;
        check("t7_free", bus.out_free_slots, 8);
        bus.in_rdy = 1'b1;
        step;
        check("t7_noreq", bus.out_dispatch_pc_requesting, 0);

        // asynchronous reset mid-miss
        push(32'h600, 1'b0);
        step;
        check("t6_req", bus.out_dispatch_pc_requesting, 1);
        in_rst = 1'b1;
        #1;
        check("t6_req_rst", bus.out_dispatch_pc_requesting, 0);
        check("t6_addr_rst", bus.out_dispatch_pc_addr, 0);
        #1;
        in_rst = 1'b0;
        respond(32'h66);
        check("t6_late", bus.out_pc_last_enable, 0);
        step;
        check("t6_dec", bus.out_decoder_decode_enable, 0);
        check("t6_free", bus.out_free_slots, 8);
        push(32'h700, 1'b0);
        step;
        check("t6_req2", bus.out_dispatch_pc_requesting, 1);
        check("t6_addr2", bus.out_dispatch_pc_addr, 32'h700);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
